// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: ALU/load write ports, two read ports, clear handshake and status pulses.
interface reg_file_mp_if #(
    parameter int DW = 8,
    parameter int PW = 3
);
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          ld_en;
    logic [DW-1:0] ld_dat;
    logic [PW-1:0] rd_addrA;
    logic [PW-1:0] rd_addrB;
    logic          clr_req;
    logic [DW-1:0] datA_out;
    logic [DW-1:0] datB_out;
    logic [DW-1:0] ded_out;
    logic          clr_busy;
    logic          wr_conflict;
    logic          wr_drop;

    modport master (
        output wr_en, wr_addr, wr_dat, ld_en, ld_dat, rd_addrA, rd_addrB, clr_req,
        input  datA_out, datB_out, ded_out, clr_busy, wr_conflict, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_dat, ld_en, ld_dat, rd_addrA, rd_addrB, clr_req,
        output datA_out, datB_out, ded_out, clr_busy, wr_conflict, wr_drop
    );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised processor register file: constant regs 0/1, dual write ports with load priority,
// optional write-to-read bypass and a sequenced clear engine.
module reg_file_mp #(
    parameter int DW       = 8,
    parameter int PW       = 3,
    parameter int DED_ADDR = 2,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_mp_if.slave   bus
);
    localparam int            DEPTH = 1 << PW;
    localparam logic [PW-1:0] DED   = PW'(DED_ADDR);
    localparam logic [PW-1:0] FIRST = PW'(2);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] clr_ptr_q, clr_ptr_d;
    logic          wr_conflict_q, wr_conflict_d;
    logic          wr_drop_q, wr_drop_d;
    // Only writable registers get storage; 0 and 1 are decoded as constants.
    logic [DW-1:0] core_q [2:DEPTH-1];
    logic [DW-1:0] core_d [2:DEPTH-1];

    logic clearing, wr_live, ld_live;

    assign clearing = (state_q == CLEAR);
    assign wr_live  = bus.wr_en & ~clearing;
    assign ld_live  = bus.ld_en & ~clearing;

    // NOTE: always_comb starts from defaults so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = FIRST;
                end
            end
            CLEAR: begin
                if (clr_ptr_q == LAST) state_d = IDLE;
                else                   clr_ptr_d = clr_ptr_q + 1'b1;
            end
        endcase
    end

    always_comb begin
        core_d = core_q;
        for (int i = 2; i < DEPTH; i++) begin
            if (clearing) begin
                if (clr_ptr_q == PW'(i)) core_d[i] = '0;
            end else begin
                if (bus.wr_en && bus.wr_addr == PW'(i)) core_d[i] = bus.wr_dat;
                // Load port assigned last so it wins a same-address collision.
                if (bus.ld_en && DED == PW'(i)) core_d[i] = bus.ld_dat;
            end
        end
        wr_conflict_d = wr_live & ld_live & (bus.wr_addr == DED);
        wr_drop_d     = clearing & (bus.wr_en | bus.ld_en);
    end

    function automatic logic [DW-1:0] read_port(input logic [PW-1:0] addr);
        logic [DW-1:0] val;
        if (addr == PW'(0))                                 val = '0;
        else if (addr == PW'(1))                            val = DW'(1);
        else if (BYPASS && ld_live && addr == DED)          val = bus.ld_dat;
        else if (BYPASS && wr_live && addr == bus.wr_addr)  val = bus.wr_dat;
        else                                                val = core_q[addr];
        return val;
    endfunction

    assign bus.datA_out    = read_port(bus.rd_addrA);
    assign bus.datB_out    = read_port(bus.rd_addrB);
    assign bus.ded_out     = read_port(DED);
    assign bus.clr_busy    = clearing;
    assign bus.wr_conflict = wr_conflict_q;
    assign bus.wr_drop     = wr_drop_q;

    // NOTE: storage is reset asynchronously too, so a reset mid-clear leaves every register at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            clr_ptr_q     <= FIRST;
            wr_conflict_q <= 1'b0;
            wr_drop_q     <= 1'b0;
            for (int i = 2; i < DEPTH; i++) core_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wr_conflict_q <= wr_conflict_d;
            wr_drop_q     <= wr_drop_d;
            core_q        <= core_d;
        end
    end
endmodule
